// File: rtl/tlc_pkg.sv
// Shared definitions for the two-road traffic-light phase sequencer.
//   - Lamp encodings LT_GREEN / LT_YELLOW / LT_RED (2 bits per light head)
//   - Phase state codes S_GA..S_RB and the raw 3-bit phase type
//   - max3() helper used to size the dwell timer
package tlc_pkg;

  localparam logic [1:0] LT_GREEN  = 2'b00;
  localparam logic [1:0] LT_YELLOW = 2'b01;
  localparam logic [1:0] LT_RED    = 2'b10;

  typedef logic [2:0] phase_t;

  typedef enum logic [2:0] {
    S_GA = 3'd0,
    S_YA = 3'd1,
    S_GB = 3'd2,
    S_YB = 3'd3,
    S_RA = 3'd4,
    S_RB = 3'd5
  } phase_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tlc_dwell_timer.sv
// Dwell timer for the phase sequencer: clears, increments, saturates.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset, forces the count to 0
//   clr   - synchronous clear (asserted on the edge that changes state)
//   cnt   - current count; 0 in the first cycle of every state
module tlc_dwell_timer #(
  parameter int unsigned Width  = 4,
  parameter int unsigned SatVal = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  output logic [Width-1:0] cnt
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q != Width'(SatVal)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/tlc_phase_sequencer.sv
// Two-road traffic-light phase sequencer: Moore FSM plus dwell timer.
// Optional all-red clearance phases are compiled in with `define TLC_ALL_RED_EN.
// Ports:
//   clk       - rising-edge clock
//   reset     - synchronous active-high reset
//   ta, tb    - traffic present on road A / road B (synchronous levels)
//   la, lb    - road A / road B light (00 green, 01 yellow, 10 red), registered
//   phase     - current state code
//   phase_chg - one-cycle pulse in the first cycle of every new state
module tlc_phase_sequencer
  import tlc_pkg::*;
#(
  parameter int unsigned GREEN_MIN      = 4,
  parameter int unsigned GREEN_MAX      = 8,
  parameter int unsigned YELLOW_CYCLES  = 2,
  parameter int unsigned ALL_RED_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ta,
  input  logic       tb,
  output logic [1:0] la,
  output logic [1:0] lb,
  output phase_t     phase,
  output logic       phase_chg
);

  localparam int unsigned TimerW =
      $clog2(max3(GREEN_MAX, YELLOW_CYCLES, ALL_RED_CYCLES) + 1);

  localparam logic [TimerW-1:0] GreenMinT = TimerW'(GREEN_MIN - 1);
  localparam logic [TimerW-1:0] GreenMaxT = TimerW'(GREEN_MAX - 1);
  localparam logic [TimerW-1:0] YellowT   = TimerW'(YELLOW_CYCLES - 1);
`ifdef TLC_ALL_RED_EN
  localparam logic [TimerW-1:0] AllRedT   = TimerW'(ALL_RED_CYCLES - 1);
`endif

  phase_e            state_q, state_d;
  logic [1:0]        la_q, la_d, lb_q, lb_d;
  logic              chg_q;
  logic [TimerW-1:0] timer;
  logic              state_change;

  assign state_change = (state_d != state_q);

  tlc_dwell_timer #(
    .Width  (TimerW),
    .SatVal (GREEN_MAX - 1)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (state_change),
    .cnt   (timer)
  );

  // Next-state logic. Green holds while its own road has demand and the other
  // does not; the timer saturates so a later drop of demand exits immediately.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_GA: if ((timer >= GreenMinT && !ta) || (timer == GreenMaxT && tb)) state_d = S_YA;
      S_GB: if ((timer >= GreenMinT && !tb) || (timer == GreenMaxT && ta)) state_d = S_YB;
`ifdef TLC_ALL_RED_EN
      S_YA: if (timer == YellowT) state_d = S_RA;
      S_YB: if (timer == YellowT) state_d = S_RB;
      S_RA: if (timer == AllRedT) state_d = S_GB;
      S_RB: if (timer == AllRedT) state_d = S_GA;
`else
      S_YA: if (timer == YellowT) state_d = S_GB;
      S_YB: if (timer == YellowT) state_d = S_GA;
`endif
      // Unused codes recover to S_GA; the state change raises phase_chg.
      default: state_d = S_GA;
    endcase
  end

  // Lights decoded from the next state so the registered heads switch in the
  // same cycle as phase. Anything not green/yellow on a road is red.
  always_comb begin
    la_d = LT_RED;
    lb_d = LT_RED;
    case (state_d)
      S_GA:    la_d = LT_GREEN;
      S_YA:    la_d = LT_YELLOW;
      S_GB:    lb_d = LT_GREEN;
      S_YB:    lb_d = LT_YELLOW;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_GA;
      la_q    <= LT_GREEN;
      lb_q    <= LT_RED;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      la_q    <= la_d;
      lb_q    <= lb_d;
      chg_q   <= state_change;
    end
  end

  assign la        = la_q;
  assign lb        = lb_q;
  assign phase     = phase_t'(state_q);
  assign phase_chg = chg_q;

endmodule
